// File: rtl/memory_access.sv
// Memory-access pipeline stage: M register plus a single-outstanding 32-bit data-bus master.
// Latency: M register loads one cycle after execute; a load/store completes in its ack cycle (zero-wait ack adds no cycle).
// Backpressure: mem_busy_m holds the M register while a request is unacked or being drained; stall_m holds it otherwise.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write_e,
    input  logic        rd_write_e,
    input  logic        mem_write_e,
    input  logic [1:0]  rd_write_src_e,
    input  logic [4:0]  rd_e,
    input  logic [31:0] pc_e,
    input  logic [31:0] alu_res_e,
    input  logic [31:0] mem_data_e,
    input  logic [31:0] csr_data_e,
    input  logic        stall_m,
    input  logic        flush_m,
    output logic        pc_write_m,
    output logic        rd_write_m,
    output logic [1:0]  rd_write_src_m,
    output logic [4:0]  rd_m,
    output logic [31:0] pc_m,
    output logic [31:0] alu_res_m,
    output logic [31:0] csr_data_m,
    output logic [31:0] mem_rdata_m,
    output logic        mem_busy_m,
    output logic        misaligned_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    typedef struct packed {
        logic        pc_write;
        logic        rd_write;
        logic        mem_write;
        logic [1:0]  rd_write_src;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] mem_data;
        logic [31:0] csr_data;
    } m_t;

    state_t      state_q, state_d;
    m_t          m_q, m_e;
    logic        memop, aligned, req, busy, m_load, take_data;
    logic [31:0] rdata_q;
    logic [31:0] bus_addr_q, bus_wdata_q;
    logic        bus_we_q;

    always_comb begin
        m_e              = '0;
        m_e.pc_write     = pc_write_e;
        m_e.rd_write     = rd_write_e;
        m_e.mem_write    = mem_write_e;
        m_e.rd_write_src = rd_write_src_e;
        m_e.rd           = rd_e;
        m_e.pc           = pc_e;
        m_e.alu_res      = alu_res_e;
        m_e.mem_data     = mem_data_e;
        m_e.csr_data     = csr_data_e;
    end

    assign memop   = m_q.mem_write | (m_q.rd_write_src == 2'b01);
    assign aligned = (m_q.alu_res[1:0] == 2'b00);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        case (state_q)
            IDLE: begin
                req = memop & aligned;
                // A flush racing an unacked first cycle still owes the bus an ack.
                if (req && !dmem_ack)
                    state_d = flush_m ? DRAIN : WAIT;
                else if (req && dmem_ack && stall_m && !flush_m)
                    state_d = DONE;
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack)
                    state_d = (stall_m && !flush_m) ? DONE : IDLE;
                else if (flush_m)
                    state_d = DRAIN;
            end
            DONE: begin
                if (flush_m || !stall_m)
                    state_d = IDLE;
            end
            DRAIN: begin
                req = 1'b1;
                if (dmem_ack)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (req & ~dmem_ack) | (state_q == DRAIN);
    assign m_load    = ~stall_m & ~busy & ~flush_m;
    assign take_data = req & dmem_ack & (state_q != DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            m_q         <= '0;
            rdata_q     <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_m)
                m_q <= '0;
            else if (m_load)
                m_q <= m_e;
            if (take_data)
                rdata_q <= dmem_rdata;
            // Bus fields are frozen once a request leaves IDLE so a flushed M register cannot disturb them.
            if (state_q == IDLE) begin
                bus_addr_q  <= {m_q.alu_res[31:2], 2'b00};
                bus_wdata_q <= m_q.mem_data;
                bus_we_q    <= m_q.mem_write;
            end
        end
    end

    assign dmem_req   = req;
    assign dmem_addr  = (state_q == IDLE) ? {m_q.alu_res[31:2], 2'b00} : bus_addr_q;
    assign dmem_wdata = (state_q == IDLE) ? m_q.mem_data : bus_wdata_q;
    assign dmem_we    = (state_q == IDLE) ? m_q.mem_write : bus_we_q;

    assign mem_busy_m   = busy;
    assign misaligned_m = memop & ~aligned;
    assign mem_rdata_m  = take_data ? dmem_rdata : ((state_q == DONE) ? rdata_q : 32'h0);

    assign pc_write_m     = m_q.pc_write;
    assign rd_write_m     = m_q.rd_write & ~misaligned_m;
    assign rd_write_src_m = m_q.rd_write_src;
    assign rd_m           = m_q.rd;
    assign pc_m           = m_q.pc;
    assign alu_res_m      = m_q.alu_res;
    assign csr_data_m     = m_q.csr_data;

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Clocking SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 pc_write_e, rd_write_e, mem_write_e  in  1 each  control bits from execute.
REQ-005 rd_write_src_e  in  2  writeback source: 00 ALU, 01 MEM (load), 10 PC+4, 11 CSR.
REQ-006 rd_e  in  5  destination register.
REQ-007 pc_e, alu_res_e, mem_data_e, csr_data_e  in  32 each  execute results; alu_res_e is the access address.
REQ-008 stall_m, flush_m  in  1 each  hazard-unit hold and bubble controls for the M register.
REQ-009 pc_write_m, rd_write_m  out  1 each  registered control to writeback.
REQ-010 rd_write_src_m  out  2; rd_m  out  5; pc_m, alu_res_m, csr_data_m  out  32 each  registered M-stage values; alu_res_m also feeds execute forwarding.
REQ-011 mem_rdata_m  out  32  load data to writeback.
REQ-012 mem_busy_m  out  1  access outstanding; the hazard unit stalls F/D/E and bubbles W while high.
REQ-013 misaligned_m  out  1  current M instruction is a memory op with alu_res_m[1:0] != 0.
REQ-014 dmem_req, dmem_we  out  1 each; dmem_addr, dmem_wdata  out  32 each  data-bus request.
REQ-015 dmem_ack  in  1; dmem_rdata  in  32  data-bus completion and read data, valid in the ack cycle.

Function
REQ-016 The M register SHALL capture all *_e inputs on an edge when rst=0, flush_m=0, stall_m=0, mem_busy_m=0; flush_m (not busy) SHALL load a bubble (all controls 0, data 0).
REQ-017 memop = mem_write_m | (rd_write_src_m==01); all accesses SHALL be 32-bit word.
REQ-018 FSM states: IDLE, WAIT, DONE, DRAIN.
REQ-019 dmem_req SHALL be 1 in IDLE when memop & aligned, in WAIT, and in DRAIN; otherwise 0.
REQ-020 dmem_addr = {alu_res_m[31:2],2'b00}; dmem_wdata = M-stage store data; dmem_we = mem_write_m; all SHALL be stable while dmem_req=1 and dmem_ack=0.
REQ-021 IDLE: req & ack & stall_m -> DONE; req & !ack -> WAIT; otherwise remain IDLE.
REQ-022 WAIT: ack & stall_m -> DONE; ack & !stall_m -> IDLE; flush_m & !ack -> DRAIN.
REQ-023 DONE: dmem_req=0; leave to IDLE on the edge the M register loads; no re-issue while held.
REQ-024 DRAIN: M register SHALL already hold a bubble; on ack -> IDLE, read data discarded.
REQ-025 mem_busy_m = (dmem_req & !dmem_ack) | (state==DRAIN).
REQ-026 mem_rdata_m = dmem_rdata in the ack cycle; a captured copy in DONE; 0 otherwise.
REQ-027 A zero-wait ack (same cycle as req) SHALL complete with mem_busy_m=0 and no extra cycle.
REQ-028 Misaligned memop: no bus request; misaligned_m=1; rd_write_m and mem write SHALL be suppressed (rd_write_m=0).
REQ-029 flush_m in IDLE/DONE SHALL bubble immediately; in WAIT it SHALL bubble the M register and move to DRAIN.
REQ-030 stall_m with no access pending SHALL hold all M outputs unchanged.

Reset
REQ-031 rst SHALL force state IDLE, dmem_req=0, mem_busy_m=0, misaligned_m=0, and all M-register outputs 0, even mid-access; a late dmem_ack after reset SHALL be ignored.

Verification
REQ-032 Load, alu_res_e=0x100, ack 2 cycles after req, rdata=0xDEADBEEF -> dmem_addr=0x100, we=0, busy high 2 cycles, mem_rdata_m=0xDEADBEEF in ack cycle.
REQ-033 Store, addr 0x204, data 0x12345678, zero-wait ack -> one-cycle req with we=1, wdata=0x12345678, busy never high.
REQ-034 Load to 0x102 -> no req, misaligned_m=1, rd_write_m=0.
REQ-035 Load, ack with stall_m=1 for 3 cycles -> DONE, req low, mem_rdata_m held at the ack data until release.
REQ-036 flush_m during WAIT, ack 2 cycles later -> req held to ack, busy high through DRAIN, M outputs bubble, data dropped.
REQ-037 rst asserted in WAIT -> next edge req=0, all outputs 0; a subsequent ack causes no state change.
